me_window_shift_ctrl: RTL and testbench
=======================================

# me_window_shift_ctrl

Sequencing controller for the motion-estimation reference window in the inter-prediction path. It fetches reference-pixel columns from reference memory with a ready/valid handshake and drives the shared `shift_en` of the bank of 8-bit pixel shift registers that forms the candidate window. It raster-scans SEARCH_W × SEARCH_H candidate positions, one vertical band at a time. Each full window is presented to the SAD unit as a candidate, and the controller stalls fetching while the SAD unit back-pressures.

## Interface
- COLS, 16, window width in columns (shift-register depth)
- SEARCH_W, 32, horizontal candidate positions per band (≥1)
- SEARCH_H, 32, vertical bands (≥1)
- ADDR_W, 16, reference memory address width
- STRIDE, 64, address increment between bands
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- base_addr  in  ADDR_W  window origin; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last candidate is accepted
- rd_req  out  1  column fetch request
- rd_addr  out  ADDR_W  column address
- rd_ready  in  1  memory presents the column this cycle
- shift_en  out  1  shift-register enable; equals rd_req && rd_ready (combinational)
- cand_valid  out  1  window holds an unconsumed candidate
- cand_ready  in  1  SAD unit accepts the candidate
- cand_x  out  $clog2(SEARCH_W)+1  candidate horizontal offset
- cand_y  out  $clog2(SEARCH_H)+1  candidate band index
- cand_last  out  1  current candidate is the final one of the scan

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE→SCAN on start: latch base_addr; col=0, y=0.
  - SCAN→DONE when y==SEARCH_H-1, all COLS+SEARCH_W-1 columns of the band are fetched, and the final candidate is accepted.
  - DONE→IDLE unconditionally after one cycle. done=1 only in DONE.
- Per band, fetch columns col = 0 … COLS+SEARCH_W-2. rd_addr = base + y*STRIDE + col, computed modulo 2^ADDR_W (wrap is allowed).
- rd_req = SCAN && col < COLS+SEARCH_W-1 && (!cand_valid || cand_ready). A held candidate is never overwritten.
- Each handshake (shift) increments col. If the post-increment col ≥ COLS, the next cycle has cand_valid=1 and cand_x = col_post - COLS.
- Acceptance (cand_valid && cand_ready) with no simultaneous shift clears cand_valid next cycle. Acceptance with a simultaneous shift keeps cand_valid high and advances cand_x.
- Band end: after the last column is fetched and its candidate is accepted, set y++ and col=0 in the same cycle. The new band refills fully; no clear is issued to the shift registers.
- cand_last = cand_valid && cand_x==SEARCH_W-1 && cand_y==SEARCH_H-1.
- start in SCAN or DONE is ignored.
- rd_ready may stay low indefinitely: hold rd_addr and rd_req stable.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally): state=IDLE and all outputs 0. Mid-scan reset aborts immediately with no done pulse.
- The first rd_req is in the cycle after start is accepted.
- Throughput: at most one shift per cycle. With no stalls, a band takes COLS+SEARCH_W-1 cycles, plus one cycle per band boundary, since the band switch happens on acceptance.
- First cand_valid is the cycle after the COLS-th shift of a band.
- cand_x, cand_y and cand_valid are registered. rd_req and shift_en are combinational from state and handshake inputs.
- Total shifts per scan = SEARCH_H*(COLS+SEARCH_W-1). Total accepted candidates = SEARCH_W*SEARCH_H.

## Structure
- Shared package `me_pkg`:
  - state enum `me_win_state_t` (IDLE/SCAN/DONE)
  - default COLS/SEARCH_W/SEARCH_H constants, used by the SAD unit too
- Optional sub-module `me_scan_counter`: col/y counters with band-end detection.
- Address generation, handshake and state machine stay in the top.

## Test plan
- COLS=4, SEARCH_W=3, SEARCH_H=2, STRIDE=100, base=0x10, rd_ready=1, cand_ready=1:
  - 12 shifts total
  - rd_addr 0x10–0x15, then 0x74–0x79
  - cand_x sequence 0,1,2 per band; cand_y 0 then 1
  - cand_last on the 6th candidate; one done pulse.
- cand_ready=0 held 5 cycles at first candidate → rd_req low, shift_en=0, cand_x stays 0; resumes on the cycle cand_ready returns.
- rd_ready toggling 1,0,1,0 → exactly one shift per rd_ready=1 cycle, and rd_addr stable during the 0 cycles.
- reset_n asserted mid-band (col=3) → outputs 0 immediately; a new start rescans from base with y=0.
- start pulsed during SCAN → ignored, no address change; base_addr=0xFFFE → rd_addr wraps to 0x0000.
- SEARCH_W=1, SEARCH_H=1 → COLS shifts, a single candidate with cand_last=1, then done.

Source files
------------

// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: window-controller states and default search geometry.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } me_win_state_t;

    localparam int unsigned ME_COLS     = 16;
    localparam int unsigned ME_SEARCH_W = 32;
    localparam int unsigned ME_SEARCH_H = 32;

endpackage

// File: rtl/me_scan_counter.sv
// Column / band counters for the reference-window raster scan, with band-end detection.
module me_scan_counter #(
    parameter int unsigned NCOL     = 47,
    parameter int unsigned SEARCH_H = 32,
    parameter int unsigned COL_W    = 6,
    parameter int unsigned Y_W      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             band_next,
    output logic [COL_W-1:0] col,
    output logic [Y_W-1:0]   y,
    output logic             col_full_c,
    output logic             last_band_c
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            y   <= '0;
        end else if (clr) begin
            col <= '0;
            y   <= '0;
        end else if (band_next) begin
            col <= '0;
            y   <= y + Y_W'(1);
        end else if (inc) begin
            col <= col + COL_W'(1);
        end
    end

    assign col_full_c  = (col == COL_W'(NCOL));
    assign last_band_c = (y == Y_W'(SEARCH_H - 1));

endmodule

// File: rtl/me_window_shift_ctrl.sv
// Reference-window sequencer: fetches pixel columns, shifts the window and hands candidates to the SAD unit.
module me_window_shift_ctrl
    import me_pkg::*;
#(
    parameter int unsigned COLS     = ME_COLS,
    parameter int unsigned SEARCH_W = ME_SEARCH_W,
    parameter int unsigned SEARCH_H = ME_SEARCH_H,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned STRIDE   = 64,
    localparam int unsigned X_W     = $clog2(SEARCH_W) + 1,
    localparam int unsigned Y_W     = $clog2(SEARCH_H) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    output logic              shift_en,
    output logic              cand_valid,
    input  logic              cand_ready,
    output logic [X_W-1:0]    cand_x,
    output logic [Y_W-1:0]    cand_y,
    output logic              cand_last
);

    localparam int unsigned NCOL  = COLS + SEARCH_W - 1;
    localparam int unsigned COL_W = $clog2(NCOL + 1);

    me_win_state_t     state_q, state_d;
    logic [ADDR_W-1:0] row_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              cand_valid_q;
    logic [X_W-1:0]    cand_x_q;
    logic [Y_W-1:0]    cand_y_q;
    logic              busy_q, done_q;

    logic [COL_W-1:0]  col;
    logic [Y_W-1:0]    y;
    logic              col_full_c, last_band_c;
    logic              start_acc_c, accept_c, band_end_c, rd_req_c, shift_c;
    logic [COL_W-1:0]  col_post_c;

    assign start_acc_c = (state_q == IDLE) && start;
    assign accept_c    = cand_valid_q && cand_ready;
    assign band_end_c  = (state_q == SCAN) && col_full_c && accept_c;
    // A held candidate blocks fetching unless it is consumed this very cycle.
    assign rd_req_c    = (state_q == SCAN) && !col_full_c && (!cand_valid_q || cand_ready);
    assign shift_c     = rd_req_c && rd_ready;
    assign col_post_c  = col + COL_W'(1);

    me_scan_counter #(
        .NCOL     (NCOL),
        .SEARCH_H (SEARCH_H),
        .COL_W    (COL_W),
        .Y_W      (Y_W)
    ) u_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (start_acc_c),
        .inc         (shift_c),
        .band_next   (band_end_c && !last_band_c),
        .col         (col),
        .y           (y),
        .col_full_c  (col_full_c),
        .last_band_c (last_band_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (band_end_c && last_band_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address generation and candidate tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_addr_q   <= '0;
            rd_addr_q    <= '0;
            cand_valid_q <= 1'b0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q <= (state_d == SCAN);
            done_q <= (state_d == DONE);
            if (start_acc_c) begin
                row_addr_q   <= base_addr;
                rd_addr_q    <= base_addr;
                cand_valid_q <= 1'b0;
            end else if (band_end_c) begin
                row_addr_q   <= row_addr_q + ADDR_W'(STRIDE);
                rd_addr_q    <= row_addr_q + ADDR_W'(STRIDE);
                cand_valid_q <= 1'b0;
            end else begin
                if (shift_c) begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
                if (shift_c && (col_post_c >= COL_W'(COLS))) begin
                    cand_valid_q <= 1'b1;
                    cand_x_q     <= X_W'(col_post_c - COL_W'(COLS));
                    cand_y_q     <= y;
                end else if (accept_c) begin
                    cand_valid_q <= 1'b0;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_req     = rd_req_c;
    assign rd_addr    = rd_addr_q;
    assign shift_en   = shift_c;
    assign cand_valid = cand_valid_q;
    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign cand_last  = cand_valid_q && (cand_x_q == X_W'(SEARCH_W - 1))
                                     && (cand_y_q == Y_W'(SEARCH_H - 1));

endmodule

// File: tb/tb_me_window_shift_ctrl.sv
// Directed bench for the reference-window sequencer: a 4x3x2 geometry instance and a 1x1 search instance.
module tb_me_window_shift_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        start, rd_ready, cand_ready;
    logic [15:0] base_addr;
    logic        busy, done, rd_req, shift_en, cand_valid, cand_last;
    logic [15:0] rd_addr;
    logic [2:0]  cand_x;
    logic [1:0]  cand_y;

    logic        start1;
    logic [15:0] base1;
    logic        busy1, done1, rd_req1, shift_en1, cand_valid1, cand_last1;
    logic [15:0] rd_addr1;
    logic [0:0]  cand_x1;
    logic [0:0]  cand_y1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    me_window_shift_ctrl #(
        .COLS(4), .SEARCH_W(3), .SEARCH_H(2), .ADDR_W(16), .STRIDE(100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .shift_en(shift_en), .cand_valid(cand_valid),
        .cand_ready(cand_ready), .cand_x(cand_x), .cand_y(cand_y),
        .cand_last(cand_last)
    );

    me_window_shift_ctrl #(
        .COLS(4), .SEARCH_W(1), .SEARCH_H(1), .ADDR_W(16), .STRIDE(100)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .base_addr(base1),
        .busy(busy1), .done(done1), .rd_req(rd_req1), .rd_addr(rd_addr1),
        .rd_ready(1'b1), .shift_en(shift_en1), .cand_valid(cand_valid1),
        .cand_ready(1'b1), .cand_x(cand_x1), .cand_y(cand_y1),
        .cand_last(cand_last1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        rd_ready   = 1'b1;
        cand_ready = 1'b1;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("wait_done", 32'(seen), 1);
        step();
    endtask

    // Unstalled full scan; expected address for the k-th shift is base + (k/6)*100 + k%6 mod 2^16.
    task automatic scan_full(input logic [15:0] b);
        int shifts, cands, dones, done_cyc;
        logic [15:0] exp_addr;
        shifts = 0; cands = 0; dones = 0; done_cyc = -1;
        start = 1'b1; base_addr = b; rd_ready = 1'b1; cand_ready = 1'b1;
        #1;
        check("idle_no_req", 32'(rd_req), 0);
        step();
        start = 1'b0;
        #1;
        check("busy_after_start", 32'(busy), 1);
        check("first_req", 32'(rd_req), 1);
        for (int i = 0; i < 24; i++) begin
            if (shift_en) begin
                exp_addr = 16'(32'(b) + 32'(shifts / 6) * 100 + 32'(shifts % 6));
                check("scan_addr", 32'(rd_addr), 32'(exp_addr));
                shifts++;
            end
            if (cand_valid && cand_ready) begin
                check("scan_cand_x", 32'(cand_x), 32'(cands % 3));
                check("scan_cand_y", 32'(cand_y), 32'(cands / 3));
                check("scan_cand_last", 32'(cand_last), 32'(cands == 5));
                cands++;
            end
            if (done) begin
                dones++;
                done_cyc = i;
            end
            step();
        end
        check("scan_shifts", 32'(shifts), 12);
        check("scan_cands", 32'(cands), 6);
        check("scan_dones", 32'(dones), 1);
        check("scan_done_cycle", 32'(done_cyc), 14);
        check("scan_idle_busy", 32'(busy), 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; rd_ready = 1'b0; cand_ready = 1'b0;
        start1 = 1'b0; base1 = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_shift_en", 32'(shift_en), 0);
        check("rst_cand_valid", 32'(cand_valid), 0);
        check("rst_cand_x", 32'(cand_x), 0);
        check("rst_cand_y", 32'(cand_y), 0);
        check("rst_cand_last", 32'(cand_last), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        scan_full(16'h0010);

        // SAD back-pressure at the first candidate.
        start = 1'b1; base_addr = 16'h0010;
        step();
        start = 1'b0; cand_ready = 1'b0; rd_ready = 1'b1;
        step(); step(); step(); step();
        #1;
        check("bp_valid", 32'(cand_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_rd_req", 32'(rd_req), 0);
            check("bp_shift", 32'(shift_en), 0);
            check("bp_cand_x", 32'(cand_x), 0);
            check("bp_addr", 32'(rd_addr), 32'h14);
            step();
        end
        cand_ready = 1'b1;
        #1;
        check("bp_resume_shift", 32'(shift_en), 1);
        step();
        check("bp_next_x", 32'(cand_x), 1);
        check("bp_next_valid", 32'(cand_valid), 1);
        wait_done(30);

        // Memory stalls on alternate cycles, then reset mid-band.
        start = 1'b1; base_addr = 16'h0020; cand_ready = 1'b1;
        step();
        start = 1'b0; rd_ready = 1'b1; #1;
        check("tog_shift0", 32'(shift_en), 1);
        check("tog_addr0", 32'(rd_addr), 32'h20);
        step(); rd_ready = 1'b0; #1;
        check("tog_shift1", 32'(shift_en), 0);
        check("tog_req1", 32'(rd_req), 1);
        check("tog_addr1", 32'(rd_addr), 32'h21);
        step(); rd_ready = 1'b1; #1;
        check("tog_shift2", 32'(shift_en), 1);
        check("tog_addr2", 32'(rd_addr), 32'h21);
        step(); rd_ready = 1'b0; #1;
        check("tog_shift3", 32'(shift_en), 0);
        check("tog_addr3", 32'(rd_addr), 32'h22);
        step(); rd_ready = 1'b1; #1;
        check("tog_shift4", 32'(shift_en), 1);
        check("tog_addr4", 32'(rd_addr), 32'h22);
        step();
        check("mid_addr", 32'(rd_addr), 32'h23);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(rd_req), 0);
        check("mid_rst_addr", 32'(rd_addr), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_shift", 32'(shift_en), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Rescan from a near-top base: start ignored in SCAN and address wraps.
        start = 1'b1; base_addr = 16'hFFFE; #1;
        check("wrap_idle_req", 32'(rd_req), 0);
        step();
        check("wrap_addr0", 32'(rd_addr), 32'hFFFE);
        check("wrap_y0", 32'(cand_y), 0);
        check("wrap_busy", 32'(busy), 1);
        start = 1'b1; base_addr = 16'h1234;
        step();
        start = 1'b0;
        check("wrap_addr1", 32'(rd_addr), 32'hFFFF);
        step();
        check("wrap_addr2", 32'(rd_addr), 32'h0000);
        wait_done(30);

        scan_full(16'hFFC0);

        // Degenerate 1x1 search on the second instance.
        start1 = 1'b1; base1 = 16'h0040;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("one_shift", 32'(shift_en1), 1);
            check("one_addr", 32'(rd_addr1), 32'h40 + 32'(i));
            step();
        end
        check("one_valid", 32'(cand_valid1), 1);
        check("one_last", 32'(cand_last1), 1);
        check("one_x", 32'(cand_x1), 0);
        check("one_no_shift", 32'(shift_en1), 0);
        step();
        check("one_done", 32'(done1), 1);
        step();
        check("one_done_pulse", 32'(done1), 0);
        check("one_idle", 32'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
